// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the core's data interface.
// Single-cycle requests, internal synchronous RAM, reads returned after
// RD_LAT cycles with a one-cycle valid strobe. No backpressure.
// Optional feature macro: DMEM_ERR_CHK_EN (misaligned / out-of-range checking
// with a sticky error flag). Without it the address wraps modulo DEPTH words.
module dmem_resp #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned AW        = 10,
    parameter int unsigned RD_LAT    = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic        dmem_en_i,
    input  logic        dmem_wr_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_rdata_valid_o,
    output logic        dmem_err_o
);

    localparam int unsigned LAST = RD_LAT - 1;

    logic [31:0]       offset;
    logic [AW-1:0]     word_idx;
    logic              req_err;
    logic              wr_en;
    logic              rd_en;

    logic [31:0]       mem [DEPTH];

    logic [RD_LAT-1:0] vld_q;
    logic [31:0]       dat_q [RD_LAT];
    logic [31:0]       hold_q;

    // Word index relative to the base; byte offset bits never select a word.
    always_comb begin
        offset   = dmem_addr_i - BASE_ADDR;
        word_idx = offset[AW+1:2];
    end

`ifdef DMEM_ERR_CHK_EN
    // Span of the window in bytes; one extra bit so DEPTH*4 cannot overflow.
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    logic err_q;

    // Addresses below BASE_ADDR wrap to huge offsets and fail the range test too.
    always_comb begin
        req_err = (|dmem_addr_i[1:0]) || ({1'b0, offset} >= SPAN);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (dmem_en_i && req_err) begin
            err_q <= 1'b1;
        end
    end

    assign dmem_err_o = err_q;
`else
    logic unused_offset;

    assign req_err       = 1'b0;
    assign dmem_err_o    = 1'b0;
    assign unused_offset = ^{offset[31:AW+2], offset[1:0]};
`endif

    // Request decode; errored writes are dropped.
    always_comb begin
        wr_en = dmem_en_i && dmem_wr_i && !req_err;
        rd_en = dmem_en_i && !dmem_wr_i;
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word_idx] <= dmem_wdata_i;
        end
    end

    // Read pipeline: stage 0 captures the RAM word, later stages only shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            if (rd_en) begin
                dat_q[0] <= req_err ? 32'h0 : mem[word_idx];
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    // Remember the last delivered word so rdata holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (vld_q[LAST]) begin
            hold_q <= dat_q[LAST];
        end
    end

    // Output: live data during the strobe, held value otherwise.
    always_comb begin
        dmem_rdata_valid_o = vld_q[LAST];
        dmem_rdata_o       = vld_q[LAST] ? dat_q[LAST] : hold_q;
    end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder at the far end of the core's data interface.
- Accepts the core's single-cycle requests (addr, wdata, en, wr) and stores words in an internal synchronous RAM.
- Returns read data after a fixed, parameterised latency with a one-cycle valid strobe.
- Sits beside the core in the SoC top; it is a drop-in in place of a dcache for bring-up and simulation.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, minimum 16.
- AW, 10, word-address width; must equal log2(DEPTH).
- RD_LAT, 1, read latency in cycles from request to valid; legal range 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.

Ports:
- clk  in  1  clock; rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- dmem_addr_i  in  32  byte address from the core.
- dmem_wdata_i  in  32  write data.
- dmem_en_i  in  1  request valid this cycle.
- dmem_wr_i  in  1  1 = write, 0 = read; qualified by dmem_en_i.
- dmem_rdata_o  out  32  read data.
- dmem_rdata_valid_o  out  1  one-cycle strobe; dmem_rdata_o is valid.
- dmem_err_o  out  1  sticky access-error flag (see Optional Feature).

Behaviour:
- Reset state: dmem_rdata_o=0, dmem_rdata_valid_o=0, dmem_err_o=0, read pipeline valid bits all 0. RAM contents are not reset.
- No backpressure. One request is accepted every cycle that dmem_en_i=1; there is no ready signal.
- Word index is (dmem_addr_i - BASE_ADDR)[AW+1:2]; addr[1:0] is ignored for the RAM access.
- Write (en=1, wr=1) at edge T: RAM word is updated at edge T. No rdata strobe is produced.
- Read (en=1, wr=0) sampled at edge T:
  - RAM is read at edge T into stage 1.
  - The result passes RD_LAT-1 further register stages.
  - dmem_rdata_valid_o=1 and dmem_rdata_o=data during exactly one cycle, following edge T+RD_LAT-1 (RD_LAT=1: the cycle right after the request).
- Pipelined reads: back-to-back reads give back-to-back valid strobes in request order. Throughput is 1 per cycle.
- Read-after-write: a read issued the cycle after a write to the same word returns the new data.
- Write-after-read: a write issued while an earlier read to the same word is still in the pipeline does not alter that read's data. Data is captured at stage 1.
- dmem_rdata_o holds its last valid value while dmem_rdata_valid_o=0.
- en=0: no RAM access. The pipeline advances with valid=0.
- Reset mid-operation: all in-flight reads are discarded. No strobe appears after rst_n deasserts until a new read is issued. RAM keeps its contents.
- Pipeline implementation: RD_LAT-deep shift register of {valid, data[31:0]}, stage 1 fed by the RAM read port. No FSM beyond this.

Optional Feature:
- Macro: DMEM_ERR_CHK_EN.
- Defined: a request is an error if either condition holds:
  - addr[1:0]!=0 (misaligned), or
  - addr outside [BASE_ADDR, BASE_ADDR+DEPTH*4).
- An errored write is dropped; the RAM is unchanged.
- An errored read still produces its valid strobe at the normal latency, with data 32'h0.
- dmem_err_o is set at the edge the errored request is sampled and stays 1 until reset.
- Not defined: no checking. The address wraps modulo DEPTH words, addr[1:0] is ignored, and dmem_err_o is tied 0.

Test Plan:
- Reset, then write 32'hDEAD_BEEF to addr 0x10, then read 0x10 (RD_LAT=1) -> valid high exactly one cycle after the read cycle, rdata=32'hDEAD_BEEF; no strobe on the write.
- RD_LAT=3: write addrs 0x0/0x4/0x8 with 1/2/3, then read them in three consecutive cycles -> three consecutive strobes starting 3 cycles after the first read, data 1, 2, 3 in order.
- Read 0x20 (holding 5), then write 9 to 0x20 next cycle, RD_LAT=2 -> strobe returns 5; a following read of 0x20 returns 9.
- RD_LAT=4: issue a read, assert rst_n=0 for one cycle two cycles later -> no valid strobe at any cycle; rdata_o=0; a re-read returns the pre-reset data.
- DMEM_ERR_CHK_EN defined, DEPTH=1024: write 7 to 0x1000 (out of range) and read 0x2 -> write dropped, read strobes with rdata 0, dmem_err_o=1 from the first errored edge and held; the word at 0x0 is unchanged.
- DMEM_ERR_CHK_EN undefined: write 0xA5 to 0x1000, then read 0x0 -> returns 0xA5 (wrap), dmem_err_o stays 0.
